whiz_bg_fetcher: RTL and testbench
==================================

// Module: whiz_bg_fetcher
// PURPOSE
//  Background tile fetcher for one scanline; sits upstream of the whizgraphics line renderer.
//  - On start_line, reads BG map entries and tile row bytes from VRAM through a 1-cycle-latency read port.
//  - Applies ScrollX/ScrollY and emits LINE_WIDTH raw 2-bit colour indices over a valid/ready stream.
//  - Palette lookup and LCD write are done downstream.
// PARAMETERS
//  LINE_WIDTH  160  pixels emitted per line
//  VRAM_AW     13   VRAM byte-address width (offset from 0x8000)
//  MAP_DIM     32   BG map tiles per row/column (power of 2)
// PORTS
//  clk           in   1   system clock; all logic on posedge
//  reset         in   1   synchronous, active-high
//  start_line    in   1   1-cycle pulse: begin fetching line ly; ignored while busy
//  ly            in   8   scanline number, 0..143
//  scx           in   8   ScrollX
//  scy           in   8   ScrollY
//  map_sel       in   1   0: map at 0x1800, 1: map at 0x1C00
//  tile_sel      in   1   1: unsigned tiles at 0x0000; 0: signed tiles, base 0x1000
//  vram_rd       out  1   read strobe
//  vram_addr     out  13  read address
//  vram_rdata    in   8   read data, valid the cycle after vram_rd
//  pix_valid     out  1   pixel available
//  pix_ready     in   1   consumer accepts pixel when pix_valid && pix_ready
//  pix_color     out  2   raw colour index {hi_bit, lo_bit}
//  pix_x         out  8   screen x of pix_color, 0..LINE_WIDTH-1
//  busy          out  1   high from the cycle after accepted start_line until line_done
//  line_done     out  1   1-cycle pulse after the last pixel is accepted
// BEHAVIOUR
//  - Reset: every output is 0; state IDLE; counters cleared.
//    Reset mid-line aborts the line; no line_done is produced.
//  - start_line latches ly, scx, scy, map_sel and tile_sel.
//    Later changes to these inputs do not affect the line in progress.
//  - bg_y = (ly+scy) mod 256; row = bg_y[2:0]; map_row = bg_y[7:3]
//  - For tile k = 0,1,2,...: map_col = (scx[7:3]+k) mod MAP_DIM (wraps 31->0).
//    map_addr = base_map + map_row*32 + map_col.
//  - Tile address from tile number t:
//    tile_sel=1: t*16 + row*2
//    tile_sel=0: 0x1000 + $signed(t)*16 + row*2, result 13 bits
//    Low byte at tile_addr, high byte at tile_addr+1.
//  - FSM states: IDLE -> NUM_A -> NUM_D -> LO_A -> LO_D -> HI_A -> HI_D -> PUSH.
//    *_A states assert vram_rd for exactly 1 cycle with the address.
//    *_D states capture vram_rdata.
//    PUSH drives 8 pixels MSB-first: color[b] = {hi[7-b], lo[7-b]}.
//  - PUSH -> NUM_A for the next tile; PUSH -> DONE after the last pixel; DONE -> IDLE.
//    line_done pulses in DONE; busy is low in IDLE.
//  - Fine scroll: in tile 0, the first scx[2:0] pixels are discarded without asserting pix_valid.
//    Tiles fetched = 20 when scx[2:0]==0, else 21. Fetching stops once pix_x has reached LINE_WIDTH-1 and been accepted.
//  - Handshake rules:
//    - pix_valid is not deasserted before acceptance.
//    - pix_color and pix_x are stable while pix_valid && !pix_ready.
//    - At most one pixel is accepted per cycle; pix_x increments by 1 per accept.
//    - pix_ready=0 stalls PUSH indefinitely.
//  - No VRAM read is issued while in PUSH; no overlapping reads; vram_rd is 0 in IDLE/DONE.
//  - Throughput with pix_ready=1: 6 fetch cycles + 8 push cycles per tile.
//    Line latency from start_line to the first pix_valid is 7 cycles when scx[2:0]=0.
//  - start_line arriving while busy, or in the same cycle as the DONE pulse, is dropped.
//    A start_line accepted in IDLE after DONE is honoured.
// STRUCTURE
//  - video_types package: bg_state_t enum, VRAM_MAP0_BASE=13'h1800, VRAM_MAP1_BASE=13'h1C00,
//    TILE_SIGNED_BASE=13'h1000, TILE_BYTES=16.
//  - One sub-module, whiz_bg_tile_shifter: loads lo/hi bytes plus a skip count and shifts out
//    2-bit pixels under valid/ready; the FSM and address generation stay in whiz_bg_fetcher.
// TESTING
//  - The bench uses a VRAM model with 1-cycle read latency and a consumer with programmable pix_ready.
//  1. Map all tile 0; tile 0 row 0 lo=8'hF0 hi=8'hCC; ly=0, scx=scy=0, tile_sel=1
//     -> pixels 3,3,1,1,2,2,0,0 repeated; 160 pixels; one line_done; first pix_valid 7 cycles after start.
//  2. Map(5,5)=3; tile 3 row 2 lo=8'hFF hi=0; ly=42, scy=0, scx=40
//     -> pix_x 0..7 all colour 1; first read address 13'h1800+5*32+5=13'h18A5.
//  3. scx=1, tile pattern as in 1 -> first pixel colour 3 (bit 6), 21 tiles fetched, exactly 160 pixels, last pix_x=159.
//  4. scx=8'hF8, scy=8'hFC, ly=10 -> map_col 31 then 0 (wrap); bg_y=6; map_row 0; row 6 addresses used.
//  5. tile_sel=0, map entry 8'h80, row 0 -> vram_addr 13'h0800 / 13'h0801.
//     Entry 8'h7F -> 13'h17F0.
//  6. Random pix_ready stalls -> sequence identical to unstalled run.
//     Assert reset at pixel 50 -> outputs 0 next cycle, no line_done; next start_line yields a full correct line.

Source files
------------

// File: rtl/whiz_bg_fetcher_pkg.sv
// Shared types, VRAM layout constants and address helpers for the background fetcher.
package whiz_bg_fetcher_pkg;

   localparam int VRAM_AW    = 13;
   localparam int MAP_DIM    = 32;
   localparam int TILE_BYTES = 16;

   localparam logic [12:0] VRAM_MAP0_BASE   = 13'h1800;
   localparam logic [12:0] VRAM_MAP1_BASE   = 13'h1C00;
   localparam logic [12:0] TILE_SIGNED_BASE = 13'h1000;

   typedef enum logic [3:0] {
      ST_IDLE  = 4'd0,
      ST_NUM_A = 4'd1,
      ST_NUM_D = 4'd2,
      ST_LO_A  = 4'd3,
      ST_LO_D  = 4'd4,
      ST_HI_A  = 4'd5,
      ST_HI_D  = 4'd6,
      ST_PUSH  = 4'd7,
      ST_DONE  = 4'd8
   } bg_state_t;

   function automatic logic [12:0] map_entry_addr(input logic       map_sel,
                                                  input logic [4:0] map_row,
                                                  input logic [4:0] map_col);
      logic [12:0] base;
      if (map_sel) begin
         base = VRAM_MAP1_BASE;
      end else begin
         base = VRAM_MAP0_BASE;
      end
      return base + {3'b000, map_row, map_col};
   endfunction

   // Signed mode sign-extends the tile number before scaling by 16; the sum wraps at 13 bits.
   function automatic logic [12:0] tile_row_addr(input logic [7:0] t,
                                                 input logic       tile_sel,
                                                 input logic [2:0] row);
      logic [12:0] base;
      if (tile_sel) begin
         base = {1'b0, t, 4'b0000};
      end else begin
         base = TILE_SIGNED_BASE + {t[7], t, 4'b0000};
      end
      return base + {9'b0_0000_0000, row, 1'b0};
   endfunction

endpackage

// File: rtl/whiz_bg_tile_shifter.sv
// Holds one tile row (lo/hi planes) and shifts out 2-bit pixels MSB-first under valid/ready.
module whiz_bg_tile_shifter
   import whiz_bg_fetcher_pkg::*;
(
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       clr_i,
   input  logic       load_i,
   input  logic [7:0] lo_i,
   input  logic [7:0] hi_i,
   input  logic [2:0] skip_i,
   input  logic       ready_i,
   output logic       valid_o,
   output logic [1:0] color_o,
   output logic       last_o
);

   logic [7:0] lo_q, lo_d;
   logic [7:0] hi_q, hi_d;
   logic [3:0] cnt_q, cnt_d;

   // Skipped pixels are dropped at load time so they cost no cycles.
   always_comb begin
      lo_d  = lo_q;
      hi_d  = hi_q;
      cnt_d = cnt_q;
      if (clr_i) begin
         lo_d  = 8'h00;
         hi_d  = 8'h00;
         cnt_d = 4'd0;
      end else if (load_i) begin
         lo_d  = lo_i << skip_i;
         hi_d  = hi_i << skip_i;
         cnt_d = 4'd8 - {1'b0, skip_i};
      end else if (valid_o && ready_i) begin
         lo_d  = {lo_q[6:0], 1'b0};
         hi_d  = {hi_q[6:0], 1'b0};
         cnt_d = cnt_q - 4'd1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         lo_q  <= 8'h00;
         hi_q  <= 8'h00;
         cnt_q <= 4'd0;
      end else begin
         lo_q  <= lo_d;
         hi_q  <= hi_d;
         cnt_q <= cnt_d;
      end
   end

   assign valid_o = (cnt_q != 4'd0);
   assign color_o = {hi_q[7], lo_q[7]};
   assign last_o  = (cnt_q == 4'd1);

endmodule

// File: rtl/whiz_bg_fetcher.sv
// Background tile fetcher: reads map entries and tile rows from VRAM for one scanline
// and streams scrolled 2-bit colour indices to the line renderer.
module whiz_bg_fetcher
   import whiz_bg_fetcher_pkg::*;
#(
   parameter int LINE_WIDTH = 160
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               start_line_i,
   input  logic [7:0]         ly_i,
   input  logic [7:0]         scx_i,
   input  logic [7:0]         scy_i,
   input  logic               map_sel_i,
   input  logic               tile_sel_i,
   output logic               vram_rd_o,
   output logic [VRAM_AW-1:0] vram_addr_o,
   input  logic [7:0]         vram_rdata_i,
   output logic               pix_valid_o,
   input  logic               pix_ready_i,
   output logic [1:0]         pix_color_o,
   output logic [7:0]         pix_x_o,
   output logic               busy_o,
   output logic               line_done_o
);

   localparam logic [7:0] LAST_X = 8'(LINE_WIDTH - 1);

   bg_state_t   state_q, state_d;
   logic [2:0]  row_q, row_d;
   logic [4:0]  map_row_q, map_row_d;
   logic [4:0]  col_q, col_d;
   logic [2:0]  fine_q, fine_d;
   logic        map_sel_q, map_sel_d;
   logic        tile_sel_q, tile_sel_d;
   logic        first_q, first_d;
   logic [7:0]  tnum_q, tnum_d;
   logic [7:0]  lo_q, lo_d;
   logic [7:0]  x_q, x_d;

   logic        vram_rd_s;
   logic [12:0] vram_addr_s;
   logic [12:0] tile_addr_s;
   logic [7:0]  bg_y_s;
   logic        load_s;
   logic        clr_s;
   logic [2:0]  skip_s;
   logic        pix_valid_s;
   logic [1:0]  pix_color_s;
   logic        last_s;
   logic        accept_s;

   assign bg_y_s      = ly_i + scy_i;
   assign tile_addr_s = tile_row_addr(tnum_q, tile_sel_q, row_q);
   assign skip_s      = first_q ? fine_q : 3'd0;
   assign accept_s    = pix_valid_s && pix_ready_i;

   // Next-state, VRAM strobe and datapath updates for the fetch/push sequence.
   always_comb begin
      state_d     = state_q;
      row_d       = row_q;
      map_row_d   = map_row_q;
      col_d       = col_q;
      fine_d      = fine_q;
      map_sel_d   = map_sel_q;
      tile_sel_d  = tile_sel_q;
      first_d     = first_q;
      tnum_d      = tnum_q;
      lo_d        = lo_q;
      x_d         = x_q;
      vram_rd_s   = 1'b0;
      vram_addr_s = 13'h0000;
      load_s      = 1'b0;
      clr_s       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_line_i) begin
               row_d      = bg_y_s[2:0];
               map_row_d  = bg_y_s[7:3];
               col_d      = scx_i[7:3];
               fine_d     = scx_i[2:0];
               map_sel_d  = map_sel_i;
               tile_sel_d = tile_sel_i;
               first_d    = 1'b1;
               x_d        = 8'd0;
               state_d    = ST_NUM_A;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_NUM_A: begin
            vram_rd_s   = 1'b1;
            vram_addr_s = map_entry_addr(map_sel_q, map_row_q, col_q);
            state_d     = ST_NUM_D;
         end
         ST_NUM_D: begin
            tnum_d  = vram_rdata_i;
            state_d = ST_LO_A;
         end
         ST_LO_A: begin
            vram_rd_s   = 1'b1;
            vram_addr_s = tile_addr_s;
            state_d     = ST_LO_D;
         end
         ST_LO_D: begin
            lo_d    = vram_rdata_i;
            state_d = ST_HI_A;
         end
         ST_HI_A: begin
            vram_rd_s   = 1'b1;
            vram_addr_s = tile_addr_s + 13'h0001;
            state_d     = ST_HI_D;
         end
         ST_HI_D: begin
            load_s  = 1'b1;
            state_d = ST_PUSH;
         end
         ST_PUSH: begin
            // The last screen pixel may fall mid-tile; the leftover pixels are flushed.
            if (accept_s && (x_q == LAST_X)) begin
               x_d     = 8'd0;
               clr_s   = 1'b1;
               state_d = ST_DONE;
            end else if (accept_s && last_s) begin
               x_d     = x_q + 8'd1;
               col_d   = col_q + 5'd1;
               first_d = 1'b0;
               state_d = ST_NUM_A;
            end else if (accept_s) begin
               x_d = x_q + 8'd1;
            end else begin
               state_d = ST_PUSH;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= ST_IDLE;
         row_q      <= 3'd0;
         map_row_q  <= 5'd0;
         col_q      <= 5'd0;
         fine_q     <= 3'd0;
         map_sel_q  <= 1'b0;
         tile_sel_q <= 1'b0;
         first_q    <= 1'b0;
         tnum_q     <= 8'h00;
         lo_q       <= 8'h00;
         x_q        <= 8'd0;
      end else begin
         state_q    <= state_d;
         row_q      <= row_d;
         map_row_q  <= map_row_d;
         col_q      <= col_d;
         fine_q     <= fine_d;
         map_sel_q  <= map_sel_d;
         tile_sel_q <= tile_sel_d;
         first_q    <= first_d;
         tnum_q     <= tnum_d;
         lo_q       <= lo_d;
         x_q        <= x_d;
      end
   end

   whiz_bg_tile_shifter u_shifter (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .clr_i   (clr_s),
      .load_i  (load_s),
      .lo_i    (lo_q),
      .hi_i    (vram_rdata_i),
      .skip_i  (skip_s),
      .ready_i (pix_ready_i),
      .valid_o (pix_valid_s),
      .color_o (pix_color_s),
      .last_o  (last_s)
   );

   assign vram_rd_o   = vram_rd_s;
   assign vram_addr_o = vram_addr_s;
   assign pix_valid_o = pix_valid_s;
   assign pix_color_o = pix_color_s;
   assign pix_x_o     = x_q;
   assign busy_o      = (state_q != ST_IDLE);
   assign line_done_o = (state_q == ST_DONE);

endmodule

// File: tb/tb_whiz_bg_fetcher.sv
// Self-checking bench for whiz_bg_fetcher: VRAM model, programmable consumer and a
// screen-coordinate reference model of the expected pixel stream.
module tb_whiz_bg_fetcher;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start_line = 1'b0;
   logic [7:0]  ly = 8'd0, scx = 8'd0, scy = 8'd0;
   logic        map_sel = 1'b0, tile_sel = 1'b1;
   logic        vram_rd;
   logic [12:0] vram_addr;
   logic [7:0]  vram_rdata = 8'h00;
   logic        pix_valid;
   logic        pix_ready = 1'b1;
   logic [1:0]  pix_color;
   logic [7:0]  pix_x;
   logic        busy;
   logic        line_done;

   always #5 clk = ~clk;

   whiz_bg_fetcher #(.LINE_WIDTH(160)) dut (
      .clk_i        (clk),
      .reset_i      (reset),
      .start_line_i (start_line),
      .ly_i         (ly),
      .scx_i        (scx),
      .scy_i        (scy),
      .map_sel_i    (map_sel),
      .tile_sel_i   (tile_sel),
      .vram_rd_o    (vram_rd),
      .vram_addr_o  (vram_addr),
      .vram_rdata_i (vram_rdata),
      .pix_valid_o  (pix_valid),
      .pix_ready_i  (pix_ready),
      .pix_color_o  (pix_color),
      .pix_x_o      (pix_x),
      .busy_o       (busy),
      .line_done_o  (line_done)
   );

   typedef struct {
      logic [7:0] ly, scx, scy;
      logic       map_sel, tile_sel, rnd_ready, mid_start, done_start;
      int         tiles, first_addr, lo_addr, map2_addr, first_color;
   } vec_t;

   logic [7:0] mem [0:8191];
   int n_cmp = 0, n_err = 0;
   int cyc = 0;
   logic [1:0] pq_col[$];
   int pq_x[$];
   int rd_q[$];
   int done_cnt = 0, viol = 0, first_cyc = -1;
   logic rnd_ready = 1'b0;
   logic prev_rd = 1'b0, prev_stall = 1'b0;
   logic [1:0] prev_col = 2'd0;
   logic [7:0] prev_x = 8'd0;

   always @(posedge clk) begin
      if (vram_rd) vram_rdata <= mem[vram_addr];
      cyc <= cyc + 1;
   end

   // Consumer and protocol monitor; owns pix_ready so acceptance is seen exactly as the DUT sees it.
   always @(negedge clk) begin
      pix_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (reset) begin
         prev_rd = 1'b0;
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && (!pix_valid || pix_color != prev_col || pix_x != prev_x)) viol++;
         if (vram_rd && (prev_rd || pix_valid)) viol++;
         if (vram_rd) rd_q.push_back(int'(vram_addr));
         if (pix_valid && first_cyc < 0) first_cyc = cyc;
         if (pix_valid && pix_ready) begin
            pq_col.push_back(pix_color);
            pq_x.push_back(int'(pix_x));
         end
         if (line_done) done_cnt++;
         prev_rd = vram_rd;
         prev_stall = pix_valid && !pix_ready;
         prev_col = pix_color;
         prev_x = pix_x;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   function automatic int map_addr_of(input logic ms, input int bg_y, input int col);
      return (ms ? 32'h1C00 : 32'h1800) + (bg_y / 8) * 32 + (col % 32);
   endfunction

   function automatic int tile_addr_of(input int t, input logic ts, input int row);
      int st;
      if (ts) return t * 16 + row * 2;
      st = (t >= 128) ? t - 256 : t;
      return (4096 + st * 16 + row * 2) % 8192;
   endfunction

   function automatic int model_color(input vec_t v, input int x);
      int bg_y, bg_x, t, ta, b, lo, hi;
      bg_y = (int'(v.ly) + int'(v.scy)) % 256;
      bg_x = (int'(v.scx) + x) % 256;
      t  = int'(mem[map_addr_of(v.map_sel, bg_y, bg_x / 8)]);
      ta = tile_addr_of(t, v.tile_sel, bg_y % 8);
      b  = 7 - (bg_x % 8);
      lo = int'(mem[ta]);
      hi = int'(mem[ta + 1]);
      return ((hi >> b) & 1) * 2 + ((lo >> b) & 1);
   endfunction

   function automatic vec_t mk(input int l, input int sx, input int sy, input int ms, input int ts,
                               input int rr, input int mid, input int dst, input int tl,
                               input int fa, input int la, input int m2, input int fc);
      vec_t v;
      v.ly = 8'(l); v.scx = 8'(sx); v.scy = 8'(sy);
      v.map_sel = 1'(ms); v.tile_sel = 1'(ts); v.rnd_ready = 1'(rr);
      v.mid_start = 1'(mid); v.done_start = 1'(dst);
      v.tiles = tl; v.first_addr = fa; v.lo_addr = la; v.map2_addr = m2; v.first_color = fc;
      return v;
   endfunction

   // Expected fields derived from the scroll rules for randomized configurations.
   function automatic vec_t mk_random();
      vec_t v;
      int bg_y;
      v = mk($urandom_range(0, 143), $urandom_range(0, 255), $urandom_range(0, 255), 1,
             $urandom_range(0, 1), $urandom_range(0, 1), 0, 0, 0, 0, 0, 0, 0);
      bg_y = (int'(v.ly) + int'(v.scy)) % 256;
      v.tiles = (v.scx[2:0] != 3'd0) ? 21 : 20;
      v.first_addr = map_addr_of(1'b1, bg_y, int'(v.scx) / 8);
      v.lo_addr = tile_addr_of(int'(mem[v.first_addr]), v.tile_sel, bg_y % 8);
      v.map2_addr = map_addr_of(1'b1, bg_y, int'(v.scx) / 8 + 1);
      v.first_color = model_color(v, 0);
      return v;
   endfunction

   task automatic run_line(input vec_t v, input string tag);
      int start_cyc;
      int got;
      int exp_c;
      logic mid_done;
      pq_col.delete(); pq_x.delete(); rd_q.delete();
      done_cnt = 0; viol = 0; first_cyc = -1; got = 0; mid_done = 1'b0;
      rnd_ready = v.rnd_ready;
      @(negedge clk);
      ly = v.ly; scx = v.scx; scy = v.scy; map_sel = v.map_sel; tile_sel = v.tile_sel;
      start_line = 1'b1;
      start_cyc = cyc;
      for (int c = 0; c < 6000; c++) begin
         @(negedge clk);
         if (line_done) begin
            got = 1;
            break;
         end
         if (v.mid_start && !mid_done && pq_x.size() >= 20) begin
            start_line = 1'b1;
            ly = ly + 8'd3; scx = 8'h55; scy = 8'h21;
            map_sel = ~map_sel; tile_sel = ~tile_sel;
            mid_done = 1'b1;
         end else begin
            start_line = 1'b0;
         end
      end
      start_line = 1'b0;
      if (got == 1 && v.done_start) begin
         start_line = 1'b1;
         @(negedge clk);
         start_line = 1'b0;
         @(negedge clk);
         check({tag, " start_in_done_dropped_busy"}, int'(busy), 0);
      end
      repeat (3) @(negedge clk);
      check({tag, " line_done_seen"}, got, 1);
      check({tag, " line_done_count"}, done_cnt, 1);
      check({tag, " pixel_count"}, pq_x.size(), 160);
      for (int i = 0; i < pq_x.size() && i < 160; i++) begin
         exp_c = model_color(v, i);
         n_cmp++;
         if (pq_x[i] != i || int'(pq_col[i]) != exp_c) begin
            n_err++;
            $display("FAIL %s pixel[%0d]: got x=%0d colour=%0d expected x=%0d colour=%0d",
                     tag, i, pq_x[i], pq_col[i], i, exp_c);
         end
      end
      check({tag, " first_colour"}, (pq_col.size() > 0) ? int'(pq_col[0]) : -1, v.first_color);
      check({tag, " vram_reads"}, rd_q.size(), 3 * v.tiles);
      check({tag, " first_map_addr"}, (rd_q.size() > 0) ? rd_q[0] : -1, v.first_addr);
      check({tag, " first_lo_addr"}, (rd_q.size() > 1) ? rd_q[1] : -1, v.lo_addr);
      check({tag, " first_hi_addr"}, (rd_q.size() > 2) ? rd_q[2] : -1, v.lo_addr + 1);
      check({tag, " second_map_addr"}, (rd_q.size() > 3) ? rd_q[3] : -1, v.map2_addr);
      check({tag, " first_valid_latency"}, first_cyc - start_cyc, 7);
      check({tag, " protocol_violations"}, viol, 0);
      check({tag, " idle_after_line"}, int'(busy), 0);
   endtask

   vec_t tbl[7];

   initial begin
      int got;
      for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
      for (int i = 'h1800; i < 'h1C00; i++) mem[i] = 8'h00;
      mem['h0000] = 8'hF0; mem['h0001] = 8'hCC;
      mem['h18A5] = 8'h03;
      mem['h0034] = 8'hFF; mem['h0035] = 8'h00;
      mem['h181F] = 8'h02;
      mem['h002C] = 8'h80; mem['h002D] = 8'h00;
      for (int c = 0; c < 32; c++) mem['h1C00 + c] = (c % 2 == 0) ? 8'h80 : 8'h7F;
      mem['h0800] = 8'h00; mem['h0801] = 8'h80;

      //           ly   scx    scy    ms ts rr mid dst tiles first    lo       map2     colour
      tbl[0] = mk(0,   0,     0,     0, 1, 0, 0,  0,  20, 'h1800, 'h0000, 'h1801, 3);
      tbl[1] = mk(42,  40,    0,     0, 1, 0, 0,  0,  20, 'h18A5, 'h0034, 'h18A6, 1);
      tbl[2] = mk(0,   1,     0,     0, 1, 0, 0,  0,  21, 'h1800, 'h0000, 'h1801, 3);
      tbl[3] = mk(10,  'hF8,  'hFC,  0, 1, 0, 0,  0,  20, 'h181F, 'h002C, 'h1800, 1);
      tbl[4] = mk(0,   0,     0,     1, 0, 0, 0,  0,  20, 'h1C00, 'h0800, 'h1C01, 2);
      tbl[5] = mk(0,   0,     0,     0, 1, 1, 1,  0,  20, 'h1800, 'h0000, 'h1801, 3);
      tbl[6] = mk(10,  'hF8,  'hFC,  0, 1, 1, 0,  1,  20, 'h181F, 'h002C, 'h1800, 1);

      repeat (3) @(negedge clk);
      check("reset_outputs_zero",
            int'({vram_rd, vram_addr, pix_valid, pix_color, pix_x, busy, line_done}), 0);
      reset = 1'b0;
      @(negedge clk);

      for (int t = 0; t < 7; t++) run_line(tbl[t], $sformatf("vec%0d", t));

      // Signed tile 0x7F reached on the second tile of the map1 line.
      run_line(tbl[4], "signed_7f");
      check("signed_7f lo_addr", (rd_q.size() > 4) ? rd_q[4] : -1, 'h17F0);
      check("signed_7f hi_addr", (rd_q.size() > 5) ? rd_q[5] : -1, 'h17F1);

      for (int r = 0; r < 4; r++) begin
         for (int c = 32; c < 1024; c++) mem['h1C00 + c] = 8'($urandom);
         run_line(mk_random(), $sformatf("rand%0d", r));
      end

      // Reset in the middle of a stalled line aborts it without a line_done.
      pq_col.delete(); pq_x.delete(); rd_q.delete();
      rnd_ready = 1'b1;
      @(negedge clk);
      ly = 8'd0; scx = 8'd0; scy = 8'd0; map_sel = 1'b0; tile_sel = 1'b1;
      start_line = 1'b1;
      @(negedge clk);
      start_line = 1'b0;
      got = 0;
      for (int c = 0; c < 3000; c++) begin
         if (pq_x.size() >= 50) begin
            got = 1;
            break;
         end
         @(negedge clk);
      end
      check("reset_mid reached_pixel_50", got, 1);
      reset = 1'b1;
      @(negedge clk);
      check("reset_mid outputs_zero",
            int'({vram_rd, vram_addr, pix_valid, pix_color, pix_x, busy, line_done}), 0);
      done_cnt = 0;
      @(negedge clk);
      reset = 1'b0;
      repeat (30) @(negedge clk);
      check("reset_mid no_line_done", done_cnt, 0);
      check("reset_mid idle", int'(busy), 0);
      run_line(tbl[0], "after_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got no completion expected completion");
      $fatal(1);
   end

endmodule
